// File: rtl/cbus_ram_ctrl.sv
// CBus burst controller for a single-port on-chip RAM: one beat per cycle, absorbs read latency.
// Optional CBUS_RAM_CTRL_RANGE_CHECK_EN suppresses writes and zeroes read data for out-of-range requests.
module cbus_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned BYTES       = DATA_WIDTH / 8,
  localparam int unsigned OFS         = $clog2(BYTES)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  input  logic                  req_is_write,
  input  logic [63:0]           req_addr,
  input  logic [3:0]            req_len,
  input  logic                  req_burst,
  input  logic [BYTES-1:0]      req_strobe,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_ready,
  output logic                  resp_last,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BYTES-1:0]      ram_strobe,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [3:0]            len_q, len_d;
  logic                  burst_q, burst_d;
  logic                  oor_q, oor_d;
  logic [4:0]            cnt_q, cnt_d;

  logic                  req_oor;
  logic                  issue, issue_last;
  logic                  rd_vld, rd_last;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[OFS-1:0], req_addr[63:OFS+ADDR_WIDTH]};

`ifdef CBUS_RAM_CTRL_RANGE_CHECK_EN
  assign req_oor = |req_addr[63:OFS+ADDR_WIDTH];
`else
  assign req_oor = 1'b0;
`endif

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign beat_addr  = burst_q ? base_q + ADDR_WIDTH'(cnt_q) : base_q;
  assign issue      = (state_q == StRead) && (cnt_q <= {1'b0, len_q});
  assign issue_last = issue && (cnt_q == {1'b0, len_q});

  generate
    if (READ_LATENCY > 0) begin : g_pipe
      logic [READ_LATENCY-1:0] vld_q, last_q;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          vld_q  <= '0;
          last_q <= '0;
        end else begin
          vld_q  <= (vld_q << 1) | READ_LATENCY'(issue);
          last_q <= (last_q << 1) | READ_LATENCY'(issue_last);
        end
      end

      assign rd_vld  = vld_q[READ_LATENCY-1];
      assign rd_last = last_q[READ_LATENCY-1];
    end else begin : g_comb
      assign rd_vld  = issue;
      assign rd_last = issue_last;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      burst_q <= 1'b0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      oor_q   <= oor_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    burst_d    = burst_q;
    oor_d      = oor_q;
    cnt_d      = cnt_q;
    resp_ready = 1'b0;
    resp_last  = 1'b0;
    resp_data  = '0;
    ram_en     = 1'b0;
    ram_addr   = '0;
    ram_strobe = '0;
    ram_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          base_d  = req_addr[OFS+ADDR_WIDTH-1:OFS];
          len_d   = req_len;
          burst_d = req_burst;
          oor_d   = req_oor;
          cnt_d   = '0;
          state_d = req_is_write ? StWrite : StRead;
        end
      end
      StWrite: begin
        ram_en     = 1'b1;
        ram_addr   = beat_addr;
        ram_strobe = oor_q ? '0 : req_strobe;
        ram_wdata  = req_data;
        resp_ready = 1'b1;
        resp_last  = (cnt_q == {1'b0, len_q});
        cnt_d      = cnt_q + 5'd1;
        if (resp_last) state_d = StIdle;
      end
      StRead: begin
        // Issue side and return side run concurrently; issue stops after len+1 addresses.
        if (issue) begin
          ram_en   = 1'b1;
          ram_addr = beat_addr;
          cnt_d    = cnt_q + 5'd1;
        end
        if (rd_vld) begin
          resp_ready = 1'b1;
          resp_last  = rd_last;
          resp_data  = oor_q ? '0 : ram_rdata;
          if (rd_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
